// File: rtl/adder_sequencer.sv
// Multi-cycle W-bit add/subtract built by sequencing an external 4-bit adder
// one nibble per cycle, least-significant nibble first.
module adder_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4*NIBBLES-1:0]   req_a,
  input  logic [4*NIBBLES-1:0]   req_b,
  input  logic                   req_cin,
  input  logic                   req_sub,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_carry,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_sum,
  output logic                   rsp_carry,
  output logic                   rsp_ovf,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [KW-1:0]  r_k;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_c;
  logic           r_carry;
  logic           r_ovf;
  logic [3:0]     r_sum_nib [NIBBLES];

  logic [3:0]     w_nib_a [NIBBLES];
  logic [3:0]     w_nib_b [NIBBLES];
  logic           w_last;
  logic           w_run;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign w_nib_a[gi]          = r_a[4*gi +: 4];
      assign w_nib_b[gi]          = r_b[4*gi +: 4];
      assign rsp_sum[4*gi +: 4]   = r_sum_nib[gi];
    end
  endgenerate

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_k == KW'(NIBBLES - 1));

  // Adder inputs are only driven while sequencing; r_c carries cin_eff into nibble 0.
  assign add_a   = w_run ? w_nib_a[r_k] : 4'd0;
  assign add_b   = w_run ? w_nib_b[r_k] : 4'd0;
  assign add_cin = w_run ? r_c : 1'b0;

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_carry = r_carry;
  assign rsp_ovf   = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < NIBBLES; i++) r_sum_nib[i] <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            // Subtract is A + ~B + 1; the caller's carry-in is irrelevant then.
            r_a     <= req_a;
            r_b     <= req_sub ? ~req_b : req_b;
            r_c     <= req_sub | req_cin;
            r_k     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum_nib[r_k] <= add_sum;
          r_c            <= add_carry;
          if (w_last) begin
            r_k     <= '0;
            r_carry <= add_carry;
            r_ovf   <= (r_a[W-1] == r_b[W-1]) && (add_sum[3] != r_a[W-1]);
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sequencer.sv
// Randomized + directed bench for adder_sequencer; external nibble adder and
// a whole-word arithmetic reference model live here.
module tb_adder_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           req_cin;
  logic           req_sub;
  logic [3:0]     add_a;
  logic [3:0]     add_b;
  logic           add_cin;
  logic [3:0]     add_sum;
  logic           add_carry;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_carry;
  logic           rsp_ovf;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  adder_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // External combinational 4-bit adder.
  always_comb {add_carry, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: returns {ovf, carry, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
    logic [W:0] full;
    logic       ovf;
    if (sub) begin
      full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    end
    return {ovf, full[W], full[W-1:0]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_rsp_sum"},   rsp_sum, 0);
    check({tag, "_rsp_carry"}, rsp_carry, 0);
    check({tag, "_rsp_ovf"},   rsp_ovf, 0);
    check({tag, "_add"},       {add_a, add_b, add_cin}, 0);
  endtask

  task automatic garbage_request();
    req_valid = 1'b1;
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    req_cin   = 1'($urandom);
    req_sub   = 1'($urandom);
  endtask

  // Entered just after a falling edge with the block idle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input int hold, input logic [W-1:0] es,
                       input logic ec, input logic eo);
    logic [W-1:0] beff;
    int n;
    beff = sub ? ~b : b;
    check("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_a = a; req_b = b; req_cin = cin; req_sub = sub;
    @(posedge clk);
    @(negedge clk);
    garbage_request();
    n = 0;
    while (!rsp_valid && n < 20) begin
      if (n < NIBBLES) begin
        check("run_add_a", add_a, a[4*n +: 4]);
        check("run_add_b", add_b, beff[4*n +: 4]);
        check("run_req_ready", req_ready, 0);
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      garbage_request();
    end
    check("latency", n, NIBBLES);
    check("rsp_sum", rsp_sum, es);
    check("rsp_carry", rsp_carry, ec);
    check("rsp_ovf", rsp_ovf, eo);
    check("done_add_zero", {add_a, add_b, add_cin}, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      garbage_request();
      check("hold_valid", rsp_valid, 1);
      check("hold_word", {rsp_carry, rsp_ovf, rsp_sum}, {ec, eo, es});
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_busy", busy, 0);
    check("post_hs_req_ready", req_ready, 1);
    $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h c=%0d v=%0d (exp %h %0d %0d)",
             a, b, cin, sub, rsp_sum, rsp_carry, rsp_ovf, es, ec, eo);
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W+1:0] r;

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
    req_cin = 1'b0; req_sub = 1'b0; rsp_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst = 1'b0;

    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 16'h2345, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h00FF, 16'h0F01, 1'b1, 1'b0, 10, 16'h1001, 1'b0, 1'b0);

    // Reset mid-RUN at k=2.
    garbage_request();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_run");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_run_clk");
    rst = 1'b0;
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0, 16'h0003, 1'b0, 1'b0);

    // Reset while in DONE.
    garbage_request();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (NIBBLES) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_done", rsp_valid, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_done");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_rst_no_rsp", rsp_valid, 0);
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      if (t % 8 == 0) a = {1'b0, {(W-1){1'b1}}};
      if (t % 8 == 1) b = {1'b1, {(W-1){1'b0}}};
      r = ref_op(a, b, cin, sub);
      do_op(a, b, cin, sub, int'($urandom_range(0, 3)), r[W-1:0], r[W], r[W+1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operation. Operand width W = 4*NIBBLES.
REQ-002 The block SHALL use one clock and one asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_a  input  W  operand A.
REQ-008 req_b  input  W  operand B.
REQ-009 req_cin  input  1  carry-in for add; ignored for subtract.
REQ-010 req_sub  input  1  1 = A-B, 0 = A+B+cin.
REQ-011 add_a  output  4  nibble to external 4-bit adder input a.
REQ-012 add_b  output  4  nibble to external adder input b.
REQ-013 add_cin  output  1  external adder carry-in.
REQ-014 add_sum  input  4  external adder sum, combinational in the same cycle.
REQ-015 add_carry  input  1  external adder carry-out, combinational in the same cycle.
REQ-016 rsp_valid  output  1  result available.
REQ-017 rsp_ready  input  1  consumer accepts result.
REQ-018 rsp_sum  output  W  result word.
REQ-019 rsp_carry  output  1  final carry-out (for subtract: 1 = no borrow).
REQ-020 rsp_ovf  output  1  signed two's-complement overflow.
REQ-021 busy  output  1  high in RUN or DONE.

Function
REQ-022 FSM states SHALL be IDLE, RUN, DONE. A nibble counter k runs 0..NIBBLES-1.
REQ-023 IDLE: req_ready=1. On req_valid&&req_ready at a clock edge, the block SHALL latch A, B_eff (B, or ~B when req_sub=1), cin_eff (req_cin, or 1 when req_sub=1) and A[W-1], then enter RUN with k=0.
REQ-024 RUN, cycle k: add_a=A[4k+3:4k], add_b=B_eff[4k+3:4k], add_cin = cin_eff if k=0, else the carry captured at the previous nibble.
REQ-025 At each RUN edge, the block SHALL write add_sum into result bits [4k+3:4k], capture add_carry, and increment k.
REQ-026 At the edge where k=NIBBLES-1, the block SHALL go to DONE and set rsp_carry=add_carry and rsp_ovf=(A[W-1]==B_eff[W-1]) && (add_sum[3]!=A[W-1]).
REQ-027 Latency: accept at edge E0; nibbles are captured at E1..E(NIBBLES); rsp_valid SHALL be high from E(NIBBLES) onward (4 cycles for the default).
REQ-028 DONE: rsp_valid=1, and rsp_sum/rsp_carry/rsp_ovf SHALL be held stable until rsp_valid&&rsp_ready, at which edge the block returns to IDLE. req_ready=1 the following cycle; there is no same-cycle re-accept.
REQ-029 req_ready SHALL be 0 in RUN and DONE. Requests offered then are not consumed, and req_* changes during RUN SHALL NOT affect the result.
REQ-030 In IDLE and DONE, add_a, add_b and add_cin SHALL drive 0.
REQ-031 All arithmetic SHALL be modulo 2^W. The carry out of the top nibble is reported only via rsp_carry.

Reset
REQ-032 While rst=1, regardless of clk, the block SHALL force: state=IDLE, k=0, req_ready=1, rsp_valid=0, busy=0, rsp_sum=0, rsp_carry=0, rsp_ovf=0, add_*=0.
REQ-033 Reset asserted mid-RUN or in DONE SHALL discard the operation. No rsp_valid pulse for it.
REQ-034 After rst deasserts, the first request SHALL be accepted on the first clk edge with req_valid=1.

Verification
REQ-035 Add 0x1234+0x1111, cin=0 -> rsp_sum=0x2345, carry=0, ovf=0; rsp_valid exactly 4 cycles after accept.
REQ-036 Add 0xFFFF+0x0001, cin=0 -> rsp_sum=0x0000, carry=1, ovf=0 (carry ripples through all nibbles).
REQ-037 Add 0x7FFF+0x0001 -> 0x8000, carry=0, ovf=1. Sub 0x8000-0x0001 -> 0x7FFF, carry=1, ovf=1.
REQ-038 Sub 0x0005-0x0007 with req_cin=0 -> rsp_sum=0xFFFE, carry=0, ovf=0 (req_cin ignored).
REQ-039 Hold rsp_ready=0 for 10 cycles in DONE with req_valid=1 and new operands -> outputs stable, req_ready=0, new request consumed only after the response handshake.
REQ-040 Assert rst during RUN at k=2, then issue 0x0001+0x0002 -> all outputs zero during reset, no stale response, next response 0x0003.
